// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback sequencer.
// The boot-constant preload table is only used when RF_PRELOAD_EN is defined.
package rf_pkg;

    localparam int DATA_W      = 48;
    localparam int ADDR_W      = 4;
    localparam int N_REGS      = 15;
    localparam int PRELOAD_LEN = 6;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        PRELOAD = 2'd1,
        RUN     = 2'd2
    } rf_seq_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_wr_t;

    localparam rf_wr_t PRELOAD_TBL [PRELOAD_LEN] = '{
        '{addr: 4'd4,  data: 48'd69540876599103},
        '{addr: 4'd6,  data: 48'd1103823438081},
        '{addr: 4'd10, data: 48'd25},
        '{addr: 4'd11, data: 48'd100},
        '{addr: 4'd12, data: 48'd4},
        '{addr: 4'd13, data: 48'd3}
    };

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping past N-1 to 0. The caller owns and advances the pointer.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found_s;
    logic [IDX_W-1:0] cand_s;

    // Scan from ptr upward with wrap; first valid requester wins.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int off = 0; off < N; off++) begin
            cand_s = IDX_W'((int'(ptr) + off) % N);
            if (!found_s && req[cand_s]) begin
                found_s     = 1'b1;
                gnt[cand_s] = 1'b1;
                idx         = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/rf_wb_sequencer.sv
// Sole owner of the regfile write port: clears all registers after reset, optionally
// writes the boot preload (RF_PRELOAD_EN), then round-robins writeback requesters.
module rf_wb_sequencer
    import rf_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rf_we,
    output logic [ADDR_W-1:0]       rf_wa,
    output logic [DATA_W-1:0]       rf_wd,
    output logic                    init_done,
    output logic                    addr_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    rf_seq_state_t     state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_wa_q, rf_wa_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    logic              init_done_q, init_done_d;
    logic              addr_err_q, addr_err_d;

    logic [N_REQ-1:0]  arb_req_s;
    logic [N_REQ-1:0]  gnt_s;
    logic [PTR_W-1:0]  gnt_idx_s;
    logic              accept_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [DATA_W-1:0] acc_data_s;

    // Grants only in RUN; a reset cycle must not hand out a grant it will then drop.
    always_comb begin
        if ((state_q == RUN) && !rst) begin
            arb_req_s = req_valid;
        end else begin
            arb_req_s = '0;
        end
    end

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (PTR_W)
    ) u_arb (
        .req (arb_req_s),
        .ptr (rr_ptr_q),
        .gnt (gnt_s),
        .idx (gnt_idx_s)
    );

    assign req_ready  = gnt_s;
    assign accept_s   = |gnt_s;
    assign acc_addr_s = req_addr[gnt_idx_s*ADDR_W +: ADDR_W];
    assign acc_data_s = req_data[gnt_idx_s*DATA_W +: DATA_W];

    // Next-state: sequencing through CLEAR/PRELOAD and the RUN-phase write path.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rr_ptr_d    = rr_ptr_q;
        rf_we_d     = 1'b0;
        rf_wa_d     = rf_wa_q;
        rf_wd_d     = rf_wd_q;
        init_done_d = init_done_q;
        addr_err_d  = 1'b0;
        case (state_q)
            CLEAR: begin
                rf_we_d = 1'b1;
                rf_wa_d = idx_q;
                rf_wd_d = '0;
                if (idx_q == ADDR_W'(N_REGS - 1)) begin
                    idx_d = '0;
`ifdef RF_PRELOAD_EN
                    state_d = PRELOAD;
`else
                    state_d     = RUN;
                    init_done_d = 1'b1;
`endif
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            PRELOAD: begin
`ifdef RF_PRELOAD_EN
                rf_we_d = 1'b1;
                rf_wa_d = PRELOAD_TBL[idx_q[2:0]].addr;
                rf_wd_d = PRELOAD_TBL[idx_q[2:0]].data;
                if (idx_q == ADDR_W'(PRELOAD_LEN - 1)) begin
                    idx_d       = '0;
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
`else
                state_d = CLEAR;
                idx_d   = '0;
`endif
            end
            RUN: begin
                if (accept_s) begin
                    if (gnt_idx_s == PTR_W'(N_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = gnt_idx_s + PTR_W'(1);
                    end
                    // Illegal destinations are still consumed so the requester never stalls.
                    if (acc_addr_s < ADDR_W'(N_REGS)) begin
                        rf_we_d = 1'b1;
                        rf_wa_d = acc_addr_s;
                        rf_wd_d = acc_data_s;
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end else begin
                    rr_ptr_d = rr_ptr_q;
                end
            end
            default: begin
                state_d = CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            idx_q       <= '0;
            rr_ptr_q    <= '0;
            rf_we_q     <= 1'b0;
            rf_wa_q     <= '0;
            rf_wd_q     <= '0;
            init_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rr_ptr_q    <= rr_ptr_d;
            rf_we_q     <= rf_we_d;
            rf_wa_q     <= rf_wa_d;
            rf_wd_q     <= rf_wd_d;
            init_done_q <= init_done_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_wa     = rf_wa_q;
    assign rf_wd     = rf_wd_q;
    assign init_done = init_done_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_rf_wb_sequencer.sv
// Self-checking bench for rf_wb_sequencer: init sequence, round-robin vectors,
// illegal address, same-address ordering and mid-sequence resets.
module tb_rf_wb_sequencer;

    localparam int NQ = 3;
    localparam int NV = 16;
`ifdef RF_PRELOAD_EN
    localparam int INIT_CYC = 22;
    localparam logic [3:0]  PL_A [6] = '{4'd4, 4'd6, 4'd10, 4'd11, 4'd12, 4'd13};
    localparam logic [47:0] PL_D [6] = '{48'd69540876599103, 48'd1103823438081,
                                         48'd25, 48'd100, 48'd4, 48'd3};
`else
    localparam int INIT_CYC = 16;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req_valid;
    logic [11:0]   req_addr;
    logic [143:0]  req_data;
    logic [2:0]    req_ready;
    logic          rf_we;
    logic [3:0]    rf_wa;
    logic [47:0]   rf_wd;
    logic          init_done;
    logic          addr_err;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [47:0] wd;
        logic        err;
    } obs_t;

    typedef struct {
        logic [2:0]  valid;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [47:0] d;
        logic [2:0]  exp_ready;
    } vec_t;

    obs_t        exp_q[$];
    vec_t        vecs[NV];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [3:0]  last_wa;
    logic [47:0] last_wd;

    rf_wb_sequencer #(.N_REQ(NQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .init_done (init_done),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_obs(input string nm);
        obs_t o;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got we=%0b wa=%0d", nm, rf_we, rf_wa);
        end else begin
            o = exp_q.pop_front();
            chk({nm, "_we"},  rf_we,    o.we);
            chk({nm, "_wa"},  rf_wa,    o.wa);
            chk({nm, "_wd"},  rf_wd,    o.wd);
            chk({nm, "_err"}, addr_err, o.err);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] v, input logic [3:0] a0, input logic [3:0] a1,
                                input logic [3:0] a2, input logic [47:0] d, input logic [2:0] r);
        vec_t t;
        t.valid = v; t.a0 = a0; t.a1 = a1; t.a2 = a2; t.d = d; t.exp_ready = r;
        return t;
    endfunction

    // Starts in cycle 1 after reset release; checks n_cycles cycles, ends at the last negedge.
    task automatic init_seq(input int n_cycles, input logic [2:0] hv);
        obs_t o;
        exp_q.delete();
        o.we = 1'b1; o.err = 1'b0; o.wa = 4'd0; o.wd = 48'd0;
        for (int r = 0; r < 15; r++) begin
            o.wa = 4'(r);
            o.wd = 48'd0;
            exp_q.push_back(o);
        end
`ifdef RF_PRELOAD_EN
        for (int p = 0; p < 6; p++) begin
            o.wa = PL_A[p];
            o.wd = PL_D[p];
            exp_q.push_back(o);
        end
`endif
        last_wa   = o.wa;
        last_wd   = o.wd;
        req_valid = hv;
        req_addr  = 12'h321;
        req_data  = {3{48'h0000_ABCD_0000}};
        for (int k = 1; k <= n_cycles; k++) begin
            @(negedge clk);
            if (k < INIT_CYC) chk("init_ready", req_ready, 3'b000);
            chk("init_done", init_done, 64'(k == INIT_CYC));
            if (k == 1) begin
                chk("rst_we", rf_we, 1'b0);
                chk("rst_err", addr_err, 1'b0);
            end else begin
                check_obs("init_write");
            end
            if (k < n_cycles) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        obs_t        o;
        int          g;
        logic [3:0]  ga;

        // grants 0,1,2,0 with all valid; then 101 skip of requester 1; illegal address; same address
        vecs[0]  = mk(3'b111, 4'd1,  4'd2,  4'd3,  48'h1000_0000_0000, 3'b001);
        vecs[1]  = mk(3'b111, 4'd4,  4'd5,  4'd6,  48'h2000_0000_0010, 3'b010);
        vecs[2]  = mk(3'b111, 4'd7,  4'd8,  4'd9,  48'h3000_0000_0020, 3'b100);
        vecs[3]  = mk(3'b111, 4'd10, 4'd11, 4'd12, 48'h4000_0000_0030, 3'b001);
        vecs[4]  = mk(3'b101, 4'd2,  4'd0,  4'd3,  48'h5000_0000_0040, 3'b100);
        vecs[5]  = mk(3'b101, 4'd2,  4'd0,  4'd3,  48'h6000_0000_0050, 3'b001);
        vecs[6]  = mk(3'b000, 4'd0,  4'd0,  4'd0,  48'h7000_0000_0060, 3'b000);
        vecs[7]  = mk(3'b010, 4'd0,  4'd14, 4'd0,  48'h8000_0000_0070, 3'b010);
        vecs[8]  = mk(3'b001, 4'hF,  4'd0,  4'd0,  48'h0000_0000_1234, 3'b001);
        vecs[9]  = mk(3'b001, 4'd5,  4'd0,  4'd0,  48'h9000_0000_0090, 3'b001);
        vecs[10] = mk(3'b011, 4'd7,  4'd7,  4'd0,  48'hA000_0000_00A0, 3'b010);
        vecs[11] = mk(3'b001, 4'd7,  4'd0,  4'd0,  48'hB000_0000_00B0, 3'b001);
        vecs[12] = mk(3'b110, 4'd0,  4'd8,  4'd9,  48'hC000_0000_00C0, 3'b010);
        vecs[13] = mk(3'b110, 4'd0,  4'd8,  4'd9,  48'hD000_0000_00D0, 3'b100);
        vecs[14] = mk(3'b000, 4'd0,  4'd0,  4'd0,  48'hE000_0000_00E0, 3'b000);
        vecs[15] = mk(3'b000, 4'd0,  4'd0,  4'd0,  48'hF000_0000_00F0, 3'b000);

        rst       = 1'b1;
        req_valid = 3'b000;
        req_addr  = 12'h000;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        init_seq(INIT_CYC, 3'b111);

        for (int i = 0; i < NV; i++) begin
            req_valid = vecs[i].valid;
            req_addr  = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
            req_data  = {vecs[i].d + 48'd2, vecs[i].d + 48'd1, vecs[i].d};
            #1;
            chk("rr_ready", req_ready, vecs[i].exp_ready);
            o.we = 1'b0; o.err = 1'b0; o.wa = last_wa; o.wd = last_wd;
            g = -1;
            for (int j = 0; j < NQ; j++) begin
                if (vecs[i].exp_ready[j]) g = j;
            end
            if (g >= 0) begin
                ga = (g == 0) ? vecs[i].a0 : ((g == 1) ? vecs[i].a1 : vecs[i].a2);
                if (ga < 4'd15) begin
                    o.we    = 1'b1;
                    o.wa    = ga;
                    o.wd    = vecs[i].d + 48'(g);
                    last_wa = o.wa;
                    last_wd = o.wd;
                end else begin
                    o.err = 1'b1;
                end
            end
            exp_q.push_back(o);
            @(posedge clk);
            @(negedge clk);
            check_obs("run_write");
            chk("run_init_done", init_done, 1'b1);
        end

        // reset while a RUN request is pending: no grant, no write, init_done drops
        req_valid = 3'b001;
        req_addr  = 12'h002;
        rst       = 1'b1;
        #1 chk("rst_run_ready", req_ready, 3'b000);
        @(posedge clk);
        #1 rst = 1'b0;

        // reset again in CLEAR at idx 7 (cycle 8), then the full sequence must restart at r0
        init_seq(8, 3'b111);
        rst = 1'b1;
        #1 chk("rst_clear_ready", req_ready, 3'b000);
        @(posedge clk);
        #1 rst = 1'b0;
        init_seq(INIT_CYC, 3'b000);

        @(posedge clk);
        @(negedge clk);
        chk("idle_we", rf_we, 1'b0);
        chk("idle_init_done", init_done, 1'b1);
        chk("idle_q_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
